// File: rtl/cskip_adder_pipe_if.sv
// ----------------------------------------------------------------------------
// cskip_adder_pipe_if
//   Bundles the operand channel, the result channel and the skip counter of
//   cskip_adder_pipe.
//
//   Parameter
//     WIDTH      operand / sum width in bits
//
//   Operand channel (producer -> adder)
//     in_valid   operand beat valid
//     in_ready   adder can take a beat this cycle
//     a, b       operands
//     cin        carry-in (ignored when sub=1)
//     sub        1: compute a - b
//   Result channel (adder -> consumer)
//     out_valid  result valid
//     out_ready  consumer takes the result
//     sum        result, modulo 2^WIDTH
//     cout       carry out of the MSB block (for sub: 1 = no borrow)
//     ovf        signed overflow (0 unless the adder is built with it)
//     skip_cnt   saturating count of block-skips over retired results
//
//   Handshake: a beat moves across a channel on a rising clk edge exactly when
//   valid and ready are both 1 at that edge. A producer keeps valid and its
//   payload steady until the transfer; ready may depend combinationally on
//   the other channel (in_ready follows out_ready), never on in_valid.
//
//   Modports: master = producer/consumer side (testbench or datapath),
//             slave  = the adder.
// ----------------------------------------------------------------------------
interface cskip_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [15:0]      skip_cnt;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, skip_cnt
    );
endinterface

// File: rtl/cskip_adder_pipe.sv
// ----------------------------------------------------------------------------
// cskip_adder_pipe
//   Pipelined carry-skip adder/subtractor. The operands are cut into
//   NB = WIDTH/BLK blocks; block k is computed in pipeline stage k by a ripple
//   adder whose carry-out is replaced by the incoming carry whenever the whole
//   block propagates. One beat per cycle, latency NB cycles, valid/ready
//   backpressure on both sides with a single global advance signal.
//
//   Parameters
//     WIDTH   operand / sum width, must be a multiple of BLK
//     BLK     skip-block width, 1..WIDTH
//
//   Ports
//     clk     clock, all state on the rising edge
//     rst     synchronous active-high reset
//     bus     cskip_adder_pipe_if.slave (operand channel, result channel,
//             skip counter)
//
//   Optional feature
//     CSKIP_OVF_EN  when defined, bus.ovf reports signed overflow, registered
//                   together with the sum; otherwise bus.ovf is tied to 0.
// ----------------------------------------------------------------------------
module cskip_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic              clk,
    input  logic              rst,
    cskip_adder_pipe_if.slave bus
);
    localparam bit CFG_OK = (BLK >= 1) && (BLK <= WIDTH) &&
                            ((WIDTH % ((BLK >= 1) ? BLK : 1)) == 0);
    localparam int NB     = (BLK >= 1) ? (WIDTH / BLK) : 1;
    // Per-beat skip tally only ever reaches NB.
    localparam int TW     = $clog2(NB + 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("cskip_adder_pipe: WIDTH must be a non-zero multiple of BLK");
    end

    // Whole pipe moves together: either the output slot is empty or it is
    // being consumed this cycle. No bubble collapse.
    logic          adv;
    logic          last_valid;
    logic [TW-1:0] last_tally;
    logic [15:0]   skip_q;
    logic [16:0]   skip_sum;

    // ------------------------------------------------------------------------
    // Stage k consumes block k of the operands. It sees a shrinking window of
    // operand bits (SW wide, block k in the low BLK bits) and forwards only the
    // still-unconsumed upper bits; the sum grows by BLK bits per stage.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NB; k++) begin : stage
        localparam int SW = WIDTH - k * BLK;

        logic [SW-1:0]        a_src;
        logic [SW-1:0]        b_src;
        logic                 c_src;
        logic                 v_src;
        logic [TW-1:0]        t_src;
        logic [(k+1)*BLK-1:0] s_nxt;
        logic [BLK-1:0]       blk_a;
        logic [BLK-1:0]       blk_b;
        logic                 prop;
        logic [BLK:0]         rip;
        logic                 c_nxt;

        logic                 v_q;
        logic                 c_q;
        logic [(k+1)*BLK-1:0] s_q;
        logic [TW-1:0]        t_q;

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + 1; b is inverted once here and the
            // inverted copy travels down the pipe.
            assign a_src = bus.a;
            assign b_src = bus.sub ? ~bus.b : bus.b;
            assign c_src = bus.sub | bus.cin;
            assign v_src = bus.in_valid;
            assign t_src = '0;
            assign s_nxt = rip[BLK-1:0];
        end else begin : g_src
            assign a_src = stage[k-1].g_fwd.a_q;
            assign b_src = stage[k-1].g_fwd.b_q;
            assign c_src = stage[k-1].c_q;
            assign v_src = stage[k-1].v_q;
            assign t_src = stage[k-1].t_q;
            assign s_nxt = {rip[BLK-1:0], stage[k-1].s_q};
        end

        assign blk_a = a_src[BLK-1:0];
        assign blk_b = b_src[BLK-1:0];
        assign prop  = &(blk_a ^ blk_b);
        assign rip   = {1'b0, blk_a} + {1'b0, blk_b} + {{BLK{1'b0}}, c_src};
        // When the block propagates, ripple carry-out equals carry-in anyway;
        // the skip mux is the carry source so the long ripple path is cut.
        assign c_nxt = prop ? c_src : rip[BLK];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
                t_q <= '0;
            end else if (adv) begin
                v_q <= v_src;
                c_q <= c_nxt;
                s_q <= s_nxt;
                t_q <= t_src + TW'(prop);
            end
        end

        if (k < NB - 1) begin : g_fwd
            logic [SW-BLK-1:0] a_q;
            logic [SW-BLK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[SW-1:BLK];
                    b_q <= b_src[SW-1:BLK];
                end
            end
        end
    end

    assign last_valid = stage[NB-1].v_q;
    assign last_tally = stage[NB-1].t_q;

    assign adv           = ~last_valid | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = last_valid;
    assign bus.sum       = stage[NB-1].s_q;
    assign bus.cout      = stage[NB-1].c_q;

    // ------------------------------------------------------------------------
    // Signed overflow. The sign bits of a and b' are the top bits of the last
    // stage's operand window, so they arrive there with the beat.
    // ------------------------------------------------------------------------
`ifdef CSKIP_OVF_EN
    logic ovf_q;
    logic ovf_nxt;

    assign ovf_nxt = (stage[NB-1].a_src[BLK-1] == stage[NB-1].b_src[BLK-1]) &
                     (stage[NB-1].rip[BLK-1]   != stage[NB-1].a_src[BLK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Skip counter: add the retiring beat's tally, clamp at all-ones.
    // ------------------------------------------------------------------------
    assign skip_sum = {1'b0, skip_q} + 17'(last_tally);

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= '0;
        end else if (last_valid & bus.out_ready) begin
            skip_q <= skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
        end
    end

    assign bus.skip_cnt = skip_q;

endmodule

// File: doc/cskip_adder_pipe.md
# cskip_adder_pipe

Parametrised, pipelined carry-skip adder/subtractor. The operand is split into WIDTH/BLK blocks; each block is one pipeline stage holding a ripple adder plus block-propagate skip mux. A valid/ready handshake with backpressure on both sides lets the block sit directly in a datapath without external stall logic. It is the clocked, width-generic successor to the fixed 32-bit/8-bit combinational carry-skip adder in the arithmetic library.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a multiple of BLK, else elaboration error
- BLK, 8, skip-block width in bits, 1..WIDTH; NB = WIDTH/BLK = pipeline depth
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  1: compute a - b (b inverted, carry-in forced 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB block (for sub: 1 = no borrow)
- ovf  out  1  signed overflow (see Configuration)
- skip_cnt  out  16  count of block-skips taken by retired results

## Operation
- Stage k (0..NB-1) registers: valid bit, carry, sum bits [k*BLK +: BLK] plus all lower sum bits, unconsumed upper operand bits (b already inverted if sub), running skip count for the beat.
- Stage k: P_k = &(a_blk ^ b_blk); ripple {c, s} = a_blk + b_blk + c_in; carry_out = P_k ? c_in : c. Skip path and ripple agree arithmetically; skip is the carry source of record.
- Stage 0 carry in = sub ? 1 : cin; b' = sub ? ~b : b.
- Per-beat skip tally increments when P_k=1; on retire (out_valid & out_ready) skip_cnt += tally, saturating at 0xFFFF.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. When adv=0 every stage holds; no bubble collapse.
- Beat accepted when in_valid & in_ready; bubbles (in_valid=0 with adv=1) propagate as invalid stages.
- sum/cout/ovf are registered outputs of stage NB-1; held stable while out_valid & ~out_ready.

## Timing
- Reset: all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, skip_cnt=0; in_ready=1 the cycle after reset deasserts. Reset mid-operation discards all in-flight beats, no result emitted.
- Latency: beat accepted at edge t → out_valid=1 after edge t+NB-1 (NB cycles, one per stage); NB=1 gives one-cycle registered adder.
- Throughput: one beat per cycle with out_ready held 1.
- Stall: out_ready=0 with out_valid=1 freezes pipe same cycle; in_ready=0 combinationally; no beat lost or duplicated.
- Simultaneous retire and accept in same cycle permitted.
- skip_cnt updates on edge of retire; saturates, never wraps.

## Configuration
- CSKIP_OVF_EN defined: ovf = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), sign bits carried along pipe; registered with sum.
- Undefined: sign-tracking registers omitted, ovf tied to 0.

## Test plan
- WIDTH=32, BLK=8: a=0xFFFFFFFF, b=0, cin=1, sub=0 → after 4 cycles sum=0x00000000, cout=1, skip_cnt=4.
- a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 → sum=2, cout=1.
- Back-to-back 8 beats a=i, b=i, out_ready toggled 1/0 every cycle → results 2*i in order, none lost, in_ready mirrors stall.
- rst pulsed 2 cycles after accepting 3 beats → out_valid stays 0, skip_cnt=0, next beat 1+1 → sum=2 after 4 cycles.
- CSKIP_OVF_EN: a=0x7FFFFFFF, b=1 → ovf=1, sum=0x80000000; without macro ovf=0.
- WIDTH=16, BLK=4 and WIDTH=8, BLK=8: 1000 random beats vs reference a+b+cin, latency 4 and 1 respectively.
